mem_port_arbiter: RTL and testbench

Shares one single-ported memory bus between the core's instruction-fetch channel and its data channel. Both channels use the core's REQ/VALID handshake. The block sits between the processor top level and the memory/interconnect. It arbitrates contending requests, latches the winning request, and holds the memory transaction until MEM_VALID. It then routes the response back to the owning channel.

---
 rtl/proc_defines.sv | 49 ++++
 rtl/arb_req_latch.sv | 27 ++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_defines.sv
//==============================================================================
// Module : proc_defines (package)
// Brief  : Shared encodings and types for the memory-port arbiter.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package proc_defines;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        CH_INSTR = 1'b0,
        CH_DATA  = 1'b1
    } arb_chan_t;

    localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // 69-bit request bundle captured at grant time
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
    } arb_req_t;

    function automatic arb_chan_t arb_pick(input logic      instr_req,
                                           input logic      data_req,
                                           input logic      round_robin,
                                           input arb_chan_t last_grant);
        arb_chan_t pick;
        if (instr_req && data_req) begin
            if (round_robin)
                pick = (last_grant == CH_INSTR) ? CH_DATA : CH_INSTR;
            else
                pick = CH_DATA;
        end else begin
            pick = data_req ? CH_DATA : CH_INSTR;
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_req_latch.sv
//==============================================================================
// Module : arb_req_latch
// Brief  : Holds the granted request bundle for the duration of a transaction.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module arb_req_latch
    import proc_defines::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load,
    input  arb_req_t d,
    output arb_req_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one memory port between instruction fetch and data access.
//          Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter
    import proc_defines::*;
#(
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        INSTR_REQ,
    input  logic [31:0] INSTR_ADR,
    output logic [31:0] INSTR_READ,
    output logic        INSTR_VALID,
    input  logic        DATA_REQ,
    input  logic [31:0] DATA_ADR,
    input  logic [31:0] DATA_WRITE,
    input  logic        DATA_WRITE_ENABLE,
    input  logic [3:0]  DATA_BE,
    output logic [31:0] DATA_READ,
    output logic        DATA_VALID,
    output logic        MEM_REQ,
    output logic [31:0] MEM_ADR,
    output logic [31:0] MEM_WRITE,
    output logic        MEM_WRITE_ENABLE,
    output logic [3:0]  MEM_BE,
    input  logic [31:0] MEM_READ,
    input  logic        MEM_VALID,
    output logic        ARB_ERR
);

    localparam logic RR_MODE = (ARB_MODE == 1);

    arb_state_t r_state;
    arb_chan_t  r_last;
    logic       r_mem_req;

    logic       w_in_grant;
    logic       w_owner_data;
    logic       w_start;
    logic       w_timeout;
    logic       w_done;
    arb_chan_t  w_pick;
    arb_req_t   w_req_d;
    arb_req_t   w_req_q;
    logic [31:0] w_rdata;

    assign w_in_grant   = (r_state != ARB_IDLE);
    assign w_owner_data = (r_state == ARB_GRANT_D);
    assign w_start      = (r_state == ARB_IDLE) && (INSTR_REQ || DATA_REQ);
    assign w_pick       = arb_pick(INSTR_REQ, DATA_REQ, RR_MODE, r_last);

    // Fetches never write, and always read the full word
    always_comb begin
        w_req_d = '0;
        if (w_pick == CH_DATA) begin
            w_req_d.adr   = DATA_ADR;
            w_req_d.wdata = DATA_WRITE;
            w_req_d.we    = DATA_WRITE_ENABLE;
            w_req_d.be    = DATA_BE;
        end else begin
            w_req_d.adr   = INSTR_ADR;
            w_req_d.wdata = 32'h0;
            w_req_d.we    = 1'b0;
            w_req_d.be    = 4'hF;
        end
    end

    arb_req_latch u_req_latch (
        .clk   (CLK),
        .rst_n (RES),
        .load  (w_start),
        .d     (w_req_d),
        .q     (w_req_q)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_wd_cnt;

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES)
            r_wd_cnt <= 16'h0;
        else if (w_start)
            r_wd_cnt <= 16'h0;
        else if (w_in_grant && !MEM_VALID)
            r_wd_cnt <= r_wd_cnt + 16'h1;
    end

    // A real response in the expiry cycle wins over the watchdog
    assign w_timeout = w_in_grant && !MEM_VALID && (r_wd_cnt == TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_done = w_in_grant && (MEM_VALID || w_timeout);

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_state   <= ARB_IDLE;
            r_last    <= CH_INSTR;
            r_mem_req <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_start) begin
                        r_state   <= (w_pick == CH_DATA) ? ARB_GRANT_D : ARB_GRANT_I;
                        r_mem_req <= 1'b1;
                    end
                end
                ARB_GRANT_I, ARB_GRANT_D: begin
                    if (w_done) begin
                        r_state   <= ARB_IDLE;
                        r_mem_req <= 1'b0;
                        r_last    <= w_owner_data ? CH_DATA : CH_INSTR;
                    end
                end
                default: begin
                    r_state   <= ARB_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign MEM_REQ          = r_mem_req;
    assign MEM_ADR          = w_req_q.adr;
    assign MEM_WRITE        = w_req_q.wdata;
    assign MEM_WRITE_ENABLE = w_req_q.we;
    assign MEM_BE           = w_req_q.be;

    assign w_rdata     = MEM_VALID ? MEM_READ : ARB_TIMEOUT_DATA;
    assign INSTR_VALID = w_done && !w_owner_data;
    assign DATA_VALID  = w_done && w_owner_data;
    assign INSTR_READ  = INSTR_VALID ? w_rdata : 32'h0;
    assign DATA_READ   = DATA_VALID ? w_rdata : 32'h0;
    assign ARB_ERR     = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Self-checking bench; unit 0 uses fixed priority, unit 1 round-robin.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int TO = 8;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        ireq[2];
    logic [31:0] iadr[2];
    logic [31:0] iread[2];
    logic        ivalid[2];
    logic        dreq[2];
    logic [31:0] dadr[2];
    logic [31:0] dwr[2];
    logic        dwe[2];
    logic [3:0]  dbe[2];
    logic [31:0] dread[2];
    logic        dvalid[2];
    logic        mreq[2];
    logic [31:0] madr[2];
    logic [31:0] mwr[2];
    logic        mwe[2];
    logic [3:0]  mbe[2];
    logic [31:0] mread[2];
    logic        mvalid[2];
    logic        aerr[2];

    int tests_run    = 0;
    int tests_failed = 0;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            mem_port_arbiter #(.ARB_MODE(g), .TIMEOUT_CYCLES(TO)) u_dut (
                .CLK(clk), .RES(rst_n),
                .INSTR_REQ(ireq[g]), .INSTR_ADR(iadr[g]), .INSTR_READ(iread[g]),
                .INSTR_VALID(ivalid[g]),
                .DATA_REQ(dreq[g]), .DATA_ADR(dadr[g]), .DATA_WRITE(dwr[g]),
                .DATA_WRITE_ENABLE(dwe[g]), .DATA_BE(dbe[g]), .DATA_READ(dread[g]),
                .DATA_VALID(dvalid[g]),
                .MEM_REQ(mreq[g]), .MEM_ADR(madr[g]), .MEM_WRITE(mwr[g]),
                .MEM_WRITE_ENABLE(mwe[g]), .MEM_BE(mbe[g]), .MEM_READ(mread[g]),
                .MEM_VALID(mvalid[g]), .ARB_ERR(aerr[g])
            );
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs(input int u);
        ireq[u] = 0; iadr[u] = 0;
        dreq[u] = 0; dadr[u] = 0; dwr[u] = 0; dwe[u] = 0; dbe[u] = 0;
        mvalid[u] = 0; mread[u] = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs(0);
        clear_inputs(1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs(0);
        clear_inputs(1);
        #3;
        for (int u = 0; u < 2; u++) begin
            tests_run++;
            if (mreq[u] !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req u%0d: got %b exp 0", u, mreq[u]); end
            tests_run++;
            if ({madr[u], mwr[u], mwe[u], mbe[u]} !== 69'd0) begin
                tests_failed++; $display("FAIL reset_mem_bus u%0d: got %h exp 0", u, {madr[u], mwr[u], mwe[u], mbe[u]});
            end
            tests_run++;
            if ({ivalid[u], dvalid[u], aerr[u]} !== 3'b000) begin
                tests_failed++; $display("FAIL reset_flags u%0d: got %b exp 000", u, {ivalid[u], dvalid[u], aerr[u]});
            end
            tests_run++;
            if ({iread[u], dread[u]} !== 64'd0) begin
                tests_failed++; $display("FAIL reset_reads u%0d: got %h exp 0", u, {iread[u], dread[u]});
            end
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        tick();
        tests_run++;
        if (mreq[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_idle: got %b exp 0", mreq[0]); end
    endtask

    task automatic test_single_fetch();
        ireq[0] = 1; iadr[0] = 32'h100;
        tick();
        tests_run++;
        if (mreq[0] !== 1'b1) begin tests_failed++; $display("FAIL fetch_latency: mem_req %b exp 1", mreq[0]); end
        tests_run++;
        if ({madr[0], mwe[0], mbe[0]} !== {32'h100, 1'b0, 4'hF}) begin
            tests_failed++; $display("FAIL fetch_bus: got %h/%b/%h exp 100/0/f", madr[0], mwe[0], mbe[0]);
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            tests_run++;
            if ({ivalid[0], iread[0]} !== 33'd0) begin
                tests_failed++; $display("FAIL fetch_wait: valid %b read %h exp 0", ivalid[0], iread[0]);
            end
            tick();
        end
        mvalid[0] = 1; mread[0] = 32'h0050_0093;
        #1;
        tests_run++;
        if ({ivalid[0], iread[0], dvalid[0]} !== {1'b1, 32'h0050_0093, 1'b0}) begin
            tests_failed++; $display("FAIL fetch_resp: ivalid %b iread %h dvalid %b exp 1 00500093 0", ivalid[0], iread[0], dvalid[0]);
        end
        tick();
        mvalid[0] = 0; ireq[0] = 0;
        tests_run++;
        if (mreq[0] !== 1'b0) begin tests_failed++; $display("FAIL fetch_release: mem_req %b exp 0", mreq[0]); end
        #1;
        tests_run++;
        if ({ivalid[0], iread[0]} !== 33'd0) begin
            tests_failed++; $display("FAIL fetch_after: valid %b read %h exp 0", ivalid[0], iread[0]);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        dreq[0] = 1; dadr[0] = 32'h2000; dwr[0] = 32'hCAFE_BABE; dwe[0] = 1; dbe[0] = 4'b0011;
        ireq[0] = 1; iadr[0] = 32'h104;
        tick();
        tests_run++;
        if ({mreq[0], madr[0], mwr[0], mwe[0], mbe[0]} !== {1'b1, 32'h2000, 32'hCAFE_BABE, 1'b1, 4'b0011}) begin
            tests_failed++; $display("FAIL simul_store_first: req %b adr %h wr %h we %b be %b", mreq[0], madr[0], mwr[0], mwe[0], mbe[0]);
        end
        mvalid[0] = 1; mread[0] = 32'h1234_5678;
        #1;
        tests_run++;
        if ({dvalid[0], ivalid[0]} !== 2'b10) begin
            tests_failed++; $display("FAIL simul_store_valid: dvalid %b ivalid %b exp 1 0", dvalid[0], ivalid[0]);
        end
        tick();
        mvalid[0] = 0; dreq[0] = 0;
        tests_run++;
        if (mreq[0] !== 1'b0) begin tests_failed++; $display("FAIL simul_gap: mem_req %b exp 0", mreq[0]); end
        tick();
        tests_run++;
        if ({mreq[0], madr[0], mwr[0], mwe[0], mbe[0]} !== {1'b1, 32'h104, 32'h0, 1'b0, 4'hF}) begin
            tests_failed++; $display("FAIL simul_fetch_second: req %b adr %h wr %h we %b be %h", mreq[0], madr[0], mwr[0], mwe[0], mbe[0]);
        end
        mvalid[0] = 1; mread[0] = 32'h0000_0013;
        #1;
        tests_run++;
        if ({ivalid[0], dvalid[0], iread[0]} !== {2'b10, 32'h13}) begin
            tests_failed++; $display("FAIL simul_fetch_valid: ivalid %b dvalid %b iread %h", ivalid[0], dvalid[0], iread[0]);
        end
        tick();
        mvalid[0] = 0; ireq[0] = 0;
        tick();
    endtask

    // Both channels held high; unit 0 always picks data, unit 1 alternates starting with data
    task automatic test_contention(input int u);
        int n;
        logic exp_data;
        ireq[u] = 1; iadr[u] = 32'h1000;
        dreq[u] = 1; dadr[u] = 32'h3000; dwe[u] = 0; dbe[u] = 4'hF; dwr[u] = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            mvalid[u] = 0;
            n = 0;
            while (!mreq[u] && n < 4) begin tick(); n++; end
            exp_data = (u == 0) ? 1'b1 : (t % 2 == 0);
            tests_run++;
            if (madr[u] !== (exp_data ? 32'h3000 : 32'h1000) || mreq[u] !== 1'b1) begin
                tests_failed++; $display("FAIL contention u%0d t%0d: req %b adr %h exp data=%b", u, t, mreq[u], madr[u], exp_data);
            end
            mvalid[u] = 1; mread[u] = $urandom;
            #1;
            tests_run++;
            if ({dvalid[u], ivalid[u]} !== {exp_data, !exp_data}) begin
                tests_failed++; $display("FAIL contention_valid u%0d t%0d: dvalid %b ivalid %b", u, t, dvalid[u], ivalid[u]);
            end
        end
        tick();
        clear_inputs(u);
        tick();
    endtask

    task automatic test_addr_change();
        dreq[0] = 1; dadr[0] = 32'h40; dwr[0] = 32'h55; dwe[0] = 0; dbe[0] = 4'hF;
        tick();
        dadr[0] = 32'h80;
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (madr[0] !== 32'h40) begin tests_failed++; $display("FAIL addr_hold c%0d: got %h exp 40", k, madr[0]); end
            if (k < 2) tick();
        end
        mvalid[0] = 1; mread[0] = 32'hA5A5_0001;
        #1;
        tests_run++;
        if ({dvalid[0], dread[0]} !== {1'b1, 32'hA5A5_0001}) begin
            tests_failed++; $display("FAIL addr_resp: dvalid %b dread %h exp 1 a5a50001", dvalid[0], dread[0]);
        end
        tick();
        clear_inputs(0);
        tick();
    endtask

    task automatic test_async_reset();
        for (int u = 0; u < 2; u++) begin ireq[u] = 1; iadr[u] = 32'h200; end
        tick();
        tests_run++;
        if ({mreq[0], mreq[1]} !== 2'b11) begin tests_failed++; $display("FAIL areset_pre: got %b%b exp 11", mreq[0], mreq[1]); end
        #2 rst_n = 0;
        #1;
        for (int u = 0; u < 2; u++) begin
            tests_run++;
            if ({mreq[u], madr[u], mbe[u], ivalid[u]} !== 38'd0) begin
                tests_failed++; $display("FAIL areset_outputs u%0d: req %b adr %h be %h iv %b exp 0", u, mreq[u], madr[u], mbe[u], ivalid[u]);
            end
            clear_inputs(u);
        end
        #3 rst_n = 1;
        tick();
        tests_run++;
        if (mreq[1] !== 1'b0) begin tests_failed++; $display("FAIL areset_idle: got %b exp 0", mreq[1]); end
        ireq[1] = 1; iadr[1] = 32'h300; dreq[1] = 1; dadr[1] = 32'h400; dbe[1] = 4'hF;
        tick();
        tests_run++;
        if ({mreq[1], madr[1]} !== {1'b1, 32'h400}) begin
            tests_failed++; $display("FAIL areset_regrant: req %b adr %h exp 1 400", mreq[1], madr[1]);
        end
        mvalid[1] = 1;
        tick();
        clear_inputs(1);
        tick();
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        dreq[0] = 1; dadr[0] = 32'h500; dbe[0] = 4'hF;
        tick();
        for (int k = 1; k <= TO; k++) begin
            #1;
            tests_run++;
            if ({dvalid[0], aerr[0], dread[0]} !== {(k == TO), (k == TO), ((k == TO) ? DEAD : 32'h0)}) begin
                tests_failed++; $display("FAIL timeout c%0d: dvalid %b err %b dread %h", k, dvalid[0], aerr[0], dread[0]);
            end
            tick();
        end
        dreq[0] = 0;
        tests_run++;
        if (mreq[0] !== 1'b0) begin tests_failed++; $display("FAIL timeout_release: mem_req %b exp 0", mreq[0]); end
        ireq[0] = 1; iadr[0] = 32'h600;
        tick();
        tests_run++;
        if ({mreq[0], madr[0]} !== {1'b1, 32'h600}) begin tests_failed++; $display("FAIL timeout_next: req %b adr %h", mreq[0], madr[0]); end
        repeat (TO - 1) tick();
        mvalid[0] = 1; mread[0] = 32'h7777_0000;
        #1;
        tests_run++;
        if ({ivalid[0], aerr[0], iread[0]} !== {2'b10, 32'h7777_0000}) begin
            tests_failed++; $display("FAIL timeout_race: ivalid %b err %b iread %h", ivalid[0], aerr[0], iread[0]);
        end
        tick();
        clear_inputs(0);
        tick();
    endtask
`else
    task automatic test_timeout();
        do_reset();
        dreq[0] = 1; dadr[0] = 32'h500; dbe[0] = 4'hF;
        for (int k = 0; k < 3 * TO; k++) begin
            tick();
            tests_run++;
            if ({mreq[0], dvalid[0], aerr[0]} !== 3'b100) begin
                tests_failed++; $display("FAIL no_timeout c%0d: req %b dvalid %b err %b exp 100", k, mreq[0], dvalid[0], aerr[0]);
            end
        end
        mvalid[0] = 1;
        tick();
        clear_inputs(0);
        tick();
    endtask
`endif

    // Transaction-level model: one outstanding job, pick on idle, complete on MEM_VALID
    task automatic test_random(input int u);
        bit busy = 0;
        int owner = 0, last = 0, wt = 0;
        bit drop[2] = '{0, 0};
        bit mv;
        logic [31:0] rd, e_adr = 0, e_wr = 0;
        logic e_we = 0;
        logic [3:0] e_be = 0;
        logic exp_iv, exp_dv;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick();
            tests_run++;
            if (mreq[u] !== busy) begin tests_failed++; $display("FAIL rnd_req u%0d c%0d: got %b exp %b", u, c, mreq[u], busy); end
            if (busy) begin
                tests_run++;
                if ({madr[u], mwr[u], mwe[u], mbe[u]} !== {e_adr, e_wr, e_we, e_be}) begin
                    tests_failed++; $display("FAIL rnd_bus u%0d c%0d: got %h exp %h", u, c,
                                             {madr[u], mwr[u], mwe[u], mbe[u]}, {e_adr, e_wr, e_we, e_be});
                end
            end
            if (drop[0]) begin ireq[u] = 0; drop[0] = 0; end
            else if (!ireq[u] && $urandom_range(0, 2) == 0) begin ireq[u] = 1; iadr[u] = $urandom; end
            else if (ireq[u] && busy && owner == 0) iadr[u] = $urandom;
            if (drop[1]) begin dreq[u] = 0; drop[1] = 0; end
            else if (!dreq[u] && $urandom_range(0, 2) == 0) begin
                dreq[u] = 1; dadr[u] = $urandom; dwr[u] = $urandom; dwe[u] = 1'($urandom); dbe[u] = 4'($urandom);
            end
            else if (dreq[u] && busy && owner == 1) begin dadr[u] = $urandom; dwr[u] = $urandom; end
            mv = busy ? (wt >= 5 || $urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            rd = $urandom;
            mvalid[u] = mv; mread[u] = rd;
            #1;
            exp_iv = busy && mv && owner == 0;
            exp_dv = busy && mv && owner == 1;
            tests_run++;
            if ({ivalid[u], dvalid[u], aerr[u]} !== {exp_iv, exp_dv, 1'b0}) begin
                tests_failed++; $display("FAIL rnd_valid u%0d c%0d: got %b exp %b", u, c, {ivalid[u], dvalid[u], aerr[u]}, {exp_iv, exp_dv, 1'b0});
            end
            tests_run++;
            if ({iread[u], dread[u]} !== {(exp_iv ? rd : 32'h0), (exp_dv ? rd : 32'h0)}) begin
                tests_failed++; $display("FAIL rnd_read u%0d c%0d: got %h/%h exp data %h", u, c, iread[u], dread[u], rd);
            end
            if (busy) begin
                if (mv) begin busy = 0; last = owner; drop[owner] = 1; end
                else wt++;
            end else if (ireq[u] || dreq[u]) begin
                if (ireq[u] && dreq[u]) owner = (u == 0) ? 1 : 1 - last;
                else owner = dreq[u] ? 1 : 0;
                busy = 1; wt = 0;
                if (owner == 1) begin e_adr = dadr[u]; e_wr = dwr[u]; e_we = dwe[u]; e_be = dbe[u]; end
                else begin e_adr = iadr[u]; e_wr = 32'h0; e_we = 1'b0; e_be = 4'hF; end
            end
        end
        clear_inputs(u);
        repeat (8) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        do_reset();
        test_contention(0);
        test_contention(1);
        test_addr_change();
        test_async_reset();
        test_timeout();
        test_random(0);
        test_random(1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
